// File: rtl/case_7_sdiv_seq.sv
// Iterative signed divider, one restoring step per cycle.
// C-style truncating quotient and remainder with ap_* handshake.
module case_7_sdiv_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din0_WIDTH-1:0] rem
);

  localparam int W  = din0_WIDTH;
  localparam int D  = din1_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam int unused_id = ID;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, nxt;

  logic          s0, s1, zdiv;
  logic [W-1:0]  a0;
  logic [W-1:0]  qr;
  logic [D-1:0]  m1;
  logic [D:0]    pr;
  logic [CW-1:0] cnt;

  logic [D:0]    sh;
  logic [D+1:0]  diff;
  logic [W-1:0]  rw, qfix, rfix;

  // state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= nxt;
  end

  // next state and handshake outputs
  always_comb begin
    nxt      = state;
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    unique case (state)
      IDLE: begin
        ap_ready = 1'b1;
        ap_idle  = 1'b1;
        if (ap_start) nxt = CALC;
      end
      CALC: if (cnt == CW'(W - 1)) nxt = FIX;
      FIX:  nxt = DONE;
      DONE: begin
        ap_done = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // trial subtraction and sign correction
  always_comb begin
    sh   = {pr[D-1:0], qr[W-1]};
    diff = {1'b0, sh} - {2'b00, m1};
    rw   = W'(pr);
    qfix = (s0 ^ s1) ? -qr : qr;
    rfix = s0 ? -rw : rw;
  end

  // operand capture, restoring steps, result registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      zdiv <= 1'b0;
      a0   <= '0;
      qr   <= '0;
      m1   <= '0;
      pr   <= '0;
      cnt  <= '0;
      dout <= '0;
      rem  <= '0;
    end else begin
      unique case (state)
        IDLE: if (ap_start) begin
          s0   <= din0[W-1];
          s1   <= din1[D-1];
          zdiv <= (din1 == '0);
          a0   <= din0;
          qr   <= din0[W-1] ? -din0 : din0;
          m1   <= din1[D-1] ? -din1 : din1;
          pr   <= '0;
          cnt  <= '0;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          qr  <= {qr[W-2:0], ~diff[D+1]};
          pr  <= diff[D+1] ? sh : diff[D:0];
        end
        FIX: begin
          if (zdiv) begin
            dout <= '1;
            rem  <= a0;
          end else begin
            dout <= dout_WIDTH'($signed(qfix));
            rem  <= rfix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_case_7_sdiv_seq.sv
// Scoreboard bench for case_7_sdiv_seq.
// Checks results, latency, done period, reset abort.
module tb_case_7_sdiv_seq;

  logic       ap_clk;
  logic       ap_rst_n;
  logic       ap_start;
  logic       ap_ready;
  logic       ap_idle;
  logic       ap_done;
  logic [7:0] din0;
  logic [3:0] din1;
  logic [7:0] dout;
  logic [7:0] rem;

  case_7_sdiv_seq #(
    .ID(1),
    .din0_WIDTH(8),
    .din1_WIDTH(4),
    .dout_WIDTH(8)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_idle(ap_idle),
    .ap_done(ap_done),
    .din0(din0),
    .din1(din1),
    .dout(dout),
    .rem(rem)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   last = -1;
  bit   held = 0;
  bit   inflight = 0;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a,
                                 input logic [3:0] b);
    exp_t e;
    int ia, ib, qi, ri;
    ia = $signed(a);
    ib = $signed(b);
    if (ib == 0) begin
      qi = -1;
      ri = ia;
    end else if (ia == -128 && ib == -1) begin
      qi = -128;
      ri = 0;
    end else begin
      qi = ia / ib;
      ri = ia % ib;
    end
    e.q = qi[7:0];
    e.r = ri[7:0];
    e.acc = 0;
    return e;
  endfunction

  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n) begin
      if (ap_done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("dout", dout, e.q);
          check("rem", rem, e.r);
          check("latency", cyc - e.acc + 1, 10);
          check("ready_done", ap_ready, 0);
          if (held && last >= 0) check("period", cyc - last, 11);
          last = cyc;
          inflight = 0;
        end
      end else if (inflight) begin
        check("idle_busy", ap_idle, 0);
        check("ready_busy", ap_ready, 0);
      end
      if (ap_start && ap_ready) begin
        e = model(din0, din1);
        e.acc = cyc + 1;
        sbq.push_back(e);
        inflight = 1;
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 40) begin
      @(negedge ap_clk);
      t++;
    end
    check("drain_timeout", sbq.size(), 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [7:0] er);
    @(posedge ap_clk);
    #1;
    din0 = a;
    din1 = b;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    din0 = 8'($urandom);
    din1 = 4'($urandom);
    drain();
    check("op_dout", dout, eq);
    check("op_rem", rem, er);
  endtask

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    din0 = '0;
    din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_rem", rem, 0);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 1);
    check("rst_idle", ap_idle, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    run_op(8'd100, 4'd7, 8'h0E, 8'h02);
    run_op(-8'sd100, 4'd7, 8'hF2, 8'hFE);
    run_op(8'd100, -4'sd7, 8'hF2, 8'h02);
    run_op(-8'sd100, -4'sd7, 8'h0E, 8'hFE);
    run_op(8'h80, 4'hF, 8'h80, 8'h00);
    run_op(8'h80, 4'h8, 8'h10, 8'h00);
    run_op(8'd37, 4'd0, 8'hFF, 8'h25);

    @(posedge ap_clk);
    #1;
    held = 1;
    last = -1;
    ap_start = 1'b1;
    repeat (57) begin
      @(posedge ap_clk);
      #1;
      din0 = 8'($urandom);
      din1 = 4'($urandom);
    end
    ap_start = 1'b0;
    drain();
    held = 0;

    run_op(8'd100, 4'd7, 8'h0E, 8'h02);
    @(posedge ap_clk);
    #1;
    din0 = 8'd100;
    din1 = 4'd7;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    repeat (4) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("abort_dout", dout, 0);
    check("abort_rem", rem, 0);
    check("abort_idle", ap_idle, 1);
    check("abort_done", ap_done, 0);
    sbq.delete();
    inflight = 0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (12) @(negedge ap_clk);
    run_op(8'd50, 4'h8, 8'hFA, 8'h02);

    @(posedge ap_clk);
    #1;
    held = 1;
    last = -1;
    ap_start = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        int t;
        din0 = 8'(a);
        din1 = 4'(b);
        t = 0;
        do begin
          @(negedge ap_clk);
          t++;
        end while (!ap_ready && t < 20);
        if (!ap_ready) check("accept_timeout", t, 0);
        @(posedge ap_clk);
        #1;
      end
    end
    ap_start = 1'b0;
    drain();
    held = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
